// File: rtl/stage4_pow2_accum.sv
// Softmax stage 4: buffers a vector of Q6.10 2^x values while summing them,
// then replays each element alongside the exact vector sum, one per cycle.
//   state | meaning
//   ACCUM | accepting elements, building count and sum
//   DRAIN | replaying buffered elements with the final sum
module stage4_pow2_accum #(
    parameter int DEPTH = 64,
    parameter int SUM_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic [15:0]      pow_in,
    input  logic             last_in,
    output logic             ready_in,
    output logic             valid_out,
    output logic [15:0]      pow_out,
    output logic [SUM_W-1:0] sum_out,
    output logic             last_out,
    output logic             drop_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [SUM_W-1:0]   r_sum;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [15:0]        r_buf [DEPTH];

    logic               w_accept;
    logic               w_last_acc;
    logic               w_drain;
    logic               w_drain_last;

    assign ready_in     = (r_state == ACCUM);
    assign w_accept     = en & valid_in & ready_in;
    // a full buffer closes the vector even without last_in
    assign w_last_acc   = w_accept & (last_in | (r_count == CNT_W'(DEPTH - 1)));
    assign w_drain      = en & (r_state == DRAIN);
    assign w_drain_last = w_drain & ({1'b0, r_rd_ptr} == (r_count - CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM: if (w_last_acc)   w_state_nxt = DRAIN;
            DRAIN: if (w_drain_last) w_state_nxt = ACCUM;
            default:                 w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_sum    <= '0;
            r_rd_ptr <= '0;
        end else if (en) begin
            if (r_state == ACCUM) begin
                if (w_accept) begin
                    r_count <= r_count + CNT_W'(1);
                    r_sum   <= r_sum + {{(SUM_W-16){1'b0}}, pow_in};
                end
                if (w_last_acc) begin
                    r_rd_ptr <= '0;
                end
            end else if (w_drain_last) begin
                r_count  <= '0;
                r_sum    <= '0;
                r_rd_ptr <= '0;
            end else begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // buffer contents are don't-care after reset, so no reset branch
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_count[PTR_W-1:0]] <= pow_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            pow_out   <= '0;
            sum_out   <= '0;
        end else if (en) begin
            if (w_drain) begin
                valid_out <= 1'b1;
                pow_out   <= r_buf[r_rd_ptr];
                sum_out   <= r_sum;
                last_out  <= w_drain_last;
            end else begin
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err <= 1'b0;
        end else if (en & valid_in & ~ready_in) begin
            drop_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stage4_pow2_accum.sv
// Directed bench for stage4_pow2_accum: a reference model queues expected
// replay beats as elements are driven; a monitor pops and compares them.
module tb_stage4_pow2_accum;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        valid_in;
    logic [15:0] pow_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [15:0] pow_out;
    logic [21:0] sum_out;
    logic        last_out;
    logic        drop_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] pow;
        logic [21:0] sum;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] vec_q[$];
    logic [21:0] vsum = '0;

    stage4_pow2_accum #(.DEPTH(64), .SUM_W(22)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .valid_in  (valid_in),
        .pow_in    (pow_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .pow_out   (pow_out),
        .sum_out   (sum_out),
        .last_out  (last_out),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one element for one edge and update the reference model
    task automatic push_elem(input logic [15:0] p, input logic l);
        valid_in = 1'b1;
        pow_in   = p;
        last_in  = l;
        tick();
        valid_in = 1'b0;
        last_in  = 1'b0;
        vec_q.push_back(p);
        vsum = vsum + {6'b0, p};
        if (l || vec_q.size() == 64) begin
            for (int i = 0; i < vec_q.size(); i++) begin
                exp_q.push_back('{vec_q[i], vsum, logic'(i == vec_q.size() - 1)});
            end
            vec_q.delete();
            vsum = '0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_complete", exp_q.size(), 0);
    endtask

    // a beat is consumed when en is high, so stalled outputs are seen once
    always @(negedge clk) begin
        exp_t e;
        if (!rst && en && valid_out) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", valid_out, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pow_out", pow_out, e.pow);
                chk("sum_out", sum_out, e.sum);
                chk("last_out", last_out, e.last);
            end
        end
    end

    initial begin
        logic [15:0] held_pow;
        logic [21:0] held_sum;

        rst = 1'b1; en = 1'b1; valid_in = 1'b0; pow_in = '0; last_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_pow_out", pow_out, 0);
        chk("rst_sum_out", sum_out, 0);
        chk("rst_drop_err", drop_err, 0);
        chk("rst_ready_in", ready_in, 1);
        rst = 1'b0;
        tick();

        // three-element vector
        push_elem(16'h0400, 1'b0);
        push_elem(16'h0200, 1'b0);
        push_elem(16'h0800, 1'b1);
        chk("v3_ready_after_last", ready_in, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("v3_valid", valid_out, 1);
            chk("v3_ready", ready_in, (i < 2) ? 32'd0 : 32'd1);
        end
        tick();
        chk("v3_valid_done", valid_out, 0);
        chk("v3_queue_empty", exp_q.size(), 0);

        // single element
        push_elem(16'h0100, 1'b1);
        tick();
        chk("v1_valid", valid_out, 1);
        chk("v1_last", last_out, 1);
        chk("v1_ready", ready_in, 1);
        tick();
        chk("v1_valid_done", valid_out, 0);

        // full buffer forces the drain
        for (int i = 0; i < 64; i++) push_elem(16'hFFFF, 1'b0);
        chk("v64_ready_forced", ready_in, 0);
        wait_drain(100);
        tick();
        chk("v64_ready_after", ready_in, 1);
        chk("v64_drop_clear", drop_err, 0);

        // element offered during drain is dropped
        push_elem(16'h0010, 1'b0);
        push_elem(16'h0020, 1'b0);
        push_elem(16'h0030, 1'b1);
        tick();
        valid_in = 1'b1;
        pow_in   = 16'h7777;
        tick();
        valid_in = 1'b0;
        chk("drop_err_set", drop_err, 1);
        wait_drain(20);
        tick();
        chk("drop_err_sticky", drop_err, 1);

        // stall mid-drain after the second output
        push_elem(16'h0111, 1'b0);
        push_elem(16'h0222, 1'b0);
        push_elem(16'h0333, 1'b0);
        push_elem(16'h0444, 1'b1);
        tick();
        tick();
        en = 1'b0;
        held_pow = pow_out;
        held_sum = sum_out;
        chk("stall_pow_second", held_pow, 16'h0222);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", valid_out, 1);
            chk("stall_pow", pow_out, held_pow);
            chk("stall_sum", sum_out, held_sum);
            chk("stall_ready", ready_in, 0);
        end
        en = 1'b1;
        wait_drain(20);

        // reset after a partial vector
        push_elem(16'h1000, 1'b0);
        push_elem(16'h2000, 1'b0);
        rst = 1'b1;
        #3;
        chk("mid_rst_pow", pow_out, 0);
        chk("mid_rst_sum", sum_out, 0);
        chk("mid_rst_drop", drop_err, 0);
        chk("mid_rst_ready", ready_in, 1);
        rst = 1'b0;
        vec_q.delete();
        vsum = '0;
        tick();
        push_elem(16'h0400, 1'b1);
        wait_drain(20);
        chk("post_rst_sum_held", sum_out, 22'h000400);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stage4_pow2_accum.md
STAGE4_POW2_ACCUM -- requirements
Module: stage4_pow2_accum

Interface
REQ-001 Parameter DEPTH, default 64, maximum vector length buffered (power of two, >=2).
REQ-002 Parameter SUM_W, default 22, sum width; equals 16+log2(DEPTH), so the sum cannot overflow.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  global stall; when low, no state or output register changes.
REQ-006 valid_in  input  1  pow_in/last_in valid; same meaning as stage3_pow2_approx valid_out.
REQ-007 pow_in  input  16  unsigned Q6.10 2^x value from stage 3.
REQ-008 last_in  input  1  marks final element of the current softmax vector.
REQ-009 ready_in  output  1  high when an element can be accepted.
REQ-010 valid_out  output  1  pow_out/sum_out/last_out valid this cycle.
REQ-011 pow_out  output  16  buffered Q6.10 element, replayed in arrival order.
REQ-012 sum_out  output  SUM_W  unsigned Q(SUM_W-10).10 sum of all elements of the vector.
REQ-013 last_out  output  1  marks final replayed element.
REQ-014 drop_err  output  1  sticky flag: an element arrived while ready_in was low.

Function
REQ-015 FSM states ACCUM and DRAIN; reset state ACCUM with count=0, sum=0, rd_ptr=0.
REQ-016 ready_in = 1 in ACCUM and 0 in DRAIN (combinational from state).
REQ-017 Accept = en & valid_in & ready_in; on accept, buffer[count] <= pow_in, count <= count+1, sum <= sum + zero-extended pow_in.
REQ-018 ACCUM->DRAIN on an accept with last_in=1, or on an accept that makes count==DEPTH (forced last); rd_ptr <= 0.
REQ-019 In DRAIN with en=1, each edge registers valid_out=1, pow_out=buffer[rd_ptr], sum_out=final sum, last_out=(rd_ptr==count-1), and advances rd_ptr.
REQ-020 Latency: if edge k accepts the last element of an n-element vector, valid_out is high after edges k+1..k+n, exactly one element per cycle.
REQ-021 The edge that emits last_out also returns state to ACCUM and clears count and sum, so ready_in is high after edge k+n.
REQ-022 In ACCUM, valid_out, last_out are registered 0; pow_out and sum_out hold their last values.
REQ-023 en=0 freezes FSM, buffer, counters and all output registers, including mid-DRAIN; the replay resumes unchanged when en returns high.
REQ-024 en & valid_in with ready_in=0 drops the element and sets drop_err=1 until reset; the drain is unaffected.
REQ-025 Sum is exact; no saturation or rounding; pow_in is treated as unsigned.
REQ-026 Single-element vector (last_in on first accept) yields one output with last_out=1 and sum_out=pow_in.

Reset
REQ-027 rst high asynchronously forces: state ACCUM, count=0, sum=0, rd_ptr=0, valid_out=0, last_out=0, pow_out=0, sum_out=0, drop_err=0; buffer contents need not be cleared.
REQ-028 Reset mid-ACCUM or mid-DRAIN discards the partial vector; the first accept after release starts a new vector.

Verification
REQ-029 Accept 0x0400, 0x0200, 0x0800 (last on third) -> three consecutive valid_out cycles with pow_out 0x0400, 0x0200, 0x0800; sum_out=0x000E00 each; last_out only on third; ready_in low during those cycles.
REQ-030 Single element 0x0100 with last_in -> one output, pow_out=0x0100, sum_out=0x000100, last_out=1; ready_in high on the next cycle.
REQ-031 64 elements of 0xFFFF, no last_in -> forced DRAIN after 64th accept; 64 outputs, sum_out=0x3FFFC0, last_out on 64th.
REQ-032 valid_in pulse during DRAIN -> drop_err=1 and remains set; the replayed data and sum are unchanged.
REQ-033 en held low 3 cycles after the second drain output -> outputs frozen; the remaining outputs follow with no loss or duplication.
REQ-034 rst pulse after 2 of 4 elements accepted -> outputs zero; new vector 0x0400 (last) gives sum_out=0x000400.
